// File: rtl/enemy_array_collider.sv
// Multi-enemy projectile collider: per-enemy ALIVE/DEAD state machines, lowest-index
// hit selection, optional respawn timers and a saturating kill score.
module enemy_array_collider #(
  parameter int unsigned NUM_ENEMIES    = 4,
  parameter int unsigned COORD_W        = 10,
  parameter int unsigned HIT_RADIUS     = 25,
  parameter int unsigned RESPAWN_CYCLES = 0,
  parameter int unsigned SCORE_W        = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_h,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_v,
  input  logic [COORD_W-1:0]             projectile_h,
  input  logic [COORD_W-1:0]             projectile_v,
  input  logic                           projectile_valid,
  output logic [NUM_ENEMIES-1:0]         alive,
  output logic [NUM_ENEMIES-1:0]         hit,
  output logic                           projectile_consume,
  output logic [SCORE_W-1:0]             score,
  output logic                           all_cleared
);

  localparam int unsigned            CNT_W        = $clog2(RESPAWN_CYCLES + 2);
  localparam logic [CNT_W-1:0]       RESPAWN_LOAD = CNT_W'(RESPAWN_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
  localparam logic signed [COORD_W:0] RADIUS      = (COORD_W+1)'(HIT_RADIUS);
  localparam logic [SCORE_W-1:0]     SCORE_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIVE,
    S_DEAD
  } state_t;

  state_t           state_q [NUM_ENEMIES];
  state_t           state_d [NUM_ENEMIES];
  logic [CNT_W-1:0] cnt_q   [NUM_ENEMIES];
  logic [CNT_W-1:0] cnt_d   [NUM_ENEMIES];

  logic [NUM_ENEMIES-1:0] overlap;
  logic [NUM_ENEMIES-1:0] winner;
  logic [NUM_ENEMIES-1:0] hit_d;
  logic                   consume_d;
  logic                   cleared_d;
  logic [SCORE_W-1:0]     score_d;
  logic signed [COORD_W:0] dh;
  logic signed [COORD_W:0] dv;
  logic                   found;
  logic                   any_started;
  logic                   any_alive;

  // Zero-extended one extra bit so differences near the screen edges never wrap.
  always_comb begin
    overlap = '0;
    dh      = '0;
    dv      = '0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      dh = $signed({1'b0, enemy_h[i*COORD_W +: COORD_W]}) - $signed({1'b0, projectile_h});
      dv = $signed({1'b0, enemy_v[i*COORD_W +: COORD_W]}) - $signed({1'b0, projectile_v});
      overlap[i] = (dh <= RADIUS) && (dh >= -RADIUS) && (dv <= RADIUS) && (dv >= -RADIUS);
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      if (!found && projectile_valid && (state_q[i] == S_ALIVE) && overlap[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      hit                <= '0;
      projectile_consume <= 1'b0;
      score              <= '0;
      all_cleared        <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hit                <= hit_d;
      projectile_consume <= consume_d;
      score              <= score_d;
      all_cleared        <= cleared_d;
    end
  end

  // Next-state logic; start overrides kills and respawns in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    hit_d     = '0;
    consume_d = 1'b0;
    score_d   = score;
    if (start) begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        state_d[i] = S_ALIVE;
        cnt_d[i]   = '0;
      end
      score_d = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        if (winner[i]) begin
          state_d[i] = S_DEAD;
          cnt_d[i]   = RESPAWN_LOAD;
        end else if ((state_q[i] == S_DEAD) && (cnt_q[i] != '0)) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
          if (cnt_q[i] == CNT_ONE) begin
            state_d[i] = S_ALIVE;
          end
        end
      end
      hit_d     = winner;
      consume_d = |winner;
      if ((|winner) && (score != SCORE_MAX)) begin
        score_d = score + 1'b1;
      end
    end
    any_started = 1'b0;
    any_alive   = 1'b0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      if (state_d[i] != S_IDLE)  any_started = 1'b1;
      if (state_d[i] == S_ALIVE) any_alive   = 1'b1;
    end
    cleared_d = any_started && !any_alive;
  end

  // Output decode
  always_comb begin
    alive = '0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      alive[i] = (state_q[i] == S_ALIVE);
    end
  end

endmodule

// File: tb/tb_enemy_array_collider.sv
// Bench for enemy_array_collider: two instances (no respawn / 5-cycle respawn) driven
// with the same directed stimulus, checked every cycle against a behavioural model.
module tb_enemy_array_collider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  eh [4];
  logic [9:0]  ev [4];
  logic [9:0]  proj_h = '0;
  logic [9:0]  proj_v = '0;
  logic        proj_valid = 1'b0;
  logic [39:0] enemy_h;
  logic [39:0] enemy_v;

  logic [3:0]  alive0, hit0, alive5, hit5;
  logic        cons0, cons5, clr0, clr5;
  logic [15:0] score0, score5;

  int checks = 0;
  int errors = 0;

  assign enemy_h = {eh[3], eh[2], eh[1], eh[0]};
  assign enemy_v = {ev[3], ev[2], ev[1], ev[0]};

  always #5 clk = ~clk;

  enemy_array_collider #(.NUM_ENEMIES(4), .COORD_W(10), .HIT_RADIUS(25),
                         .RESPAWN_CYCLES(0), .SCORE_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .enemy_h(enemy_h), .enemy_v(enemy_v),
    .projectile_h(proj_h), .projectile_v(proj_v), .projectile_valid(proj_valid),
    .alive(alive0), .hit(hit0), .projectile_consume(cons0), .score(score0),
    .all_cleared(clr0));

  enemy_array_collider #(.NUM_ENEMIES(4), .COORD_W(10), .HIT_RADIUS(25),
                         .RESPAWN_CYCLES(5), .SCORE_W(16)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start), .enemy_h(enemy_h), .enemy_v(enemy_v),
    .projectile_h(proj_h), .projectile_v(proj_v), .projectile_valid(proj_valid),
    .alive(alive5), .hit(hit5), .projectile_consume(cons5), .score(score5),
    .all_cleared(clr5));

  // Behavioural model, index 0 = no respawn, index 1 = respawn after 5 clocks.
  logic [3:0] m_alive [2] = '{default: '0};
  logic [3:0] m_hit   [2] = '{default: '0};
  logic       m_cons  [2] = '{default: 1'b0};
  logic       m_clr   [2] = '{default: 1'b0};
  logic       m_start [2] = '{default: 1'b0};
  int         m_score [2] = '{default: 0};
  int         m_timer [2][4];
  int         respawn [2] = '{0, 5};

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int w;
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_alive[d] = '0; m_hit[d] = '0; m_cons[d] = 1'b0; m_clr[d] = 1'b0;
        m_start[d] = 1'b0; m_score[d] = 0;
        for (int i = 0; i < 4; i++) m_timer[d][i] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (start) begin
          m_alive[d] = 4'b1111; m_hit[d] = '0; m_cons[d] = 1'b0;
          m_start[d] = 1'b1; m_score[d] = 0;
          for (int i = 0; i < 4; i++) m_timer[d][i] = 0;
        end else begin
          w = -1;
          if (proj_valid)
            for (int i = 0; i < 4; i++)
              if (w < 0 && m_alive[d][i] &&
                  absd(int'(eh[i]), int'(proj_h)) <= 25 &&
                  absd(int'(ev[i]), int'(proj_v)) <= 25)
                w = i;
          m_hit[d] = '0;
          m_cons[d] = 1'b0;
          for (int i = 0; i < 4; i++)
            if (!m_alive[d][i] && m_timer[d][i] > 0) begin
              m_timer[d][i]--;
              if (m_timer[d][i] == 0) m_alive[d][i] = 1'b1;
            end
          if (w >= 0) begin
            m_alive[d][w] = 1'b0;
            m_timer[d][w] = respawn[d];
            m_hit[d][w]   = 1'b1;
            m_cons[d]     = 1'b1;
            if (m_score[d] < 65535) m_score[d]++;
          end
        end
        m_clr[d] = m_start[d] && (m_alive[d] == 4'b0000);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("alive0", 32'(alive0), 32'(m_alive[0]));
    check("hit0",   32'(hit0),   32'(m_hit[0]));
    check("cons0",  32'(cons0),  32'(m_cons[0]));
    check("score0", 32'(score0), 32'(m_score[0]));
    check("clr0",   32'(clr0),   32'(m_clr[0]));
    check("alive5", 32'(alive5), 32'(m_alive[1]));
    check("hit5",   32'(hit5),   32'(m_hit[1]));
    check("cons5",  32'(cons5),  32'(m_cons[1]));
    check("score5", 32'(score5), 32'(m_score[1]));
    check("clr5",   32'(clr5),   32'(m_clr[1]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic fire(input int h, input int v);
    proj_h = 10'(h);
    proj_v = 10'(v);
    proj_valid = 1'b1;
    cyc();
    proj_valid = 1'b0;
  endtask

  task automatic place(input int i, input int h, input int v);
    eh[i] = 10'(h);
    ev[i] = 10'(v);
  endtask

  initial begin
    int dead;
    place(0, 100, 100); place(1, 400, 400); place(2, 600, 400); place(3, 800, 400);
    #1 reset_n = 1'b0;
    repeat (2) cyc();
    check("rst_alive", 32'(alive0), 32'h0);
    check("rst_score", 32'(score0), 32'h0);
    check("rst_clr",   32'(clr0),   32'h0);
    reset_n = 1'b1;
    cyc();
    check("idle_clr", 32'(clr0), 32'h0);

    // 1: corner of the hitbox is a hit
    do_start();
    check("start_alive", 32'(alive0), 32'hf);
    fire(125, 75);
    check("t1_hit",   32'(hit0),   32'h1);
    check("t1_cons",  32'(cons0),  32'h1);
    check("t1_score", 32'(score0), 32'h1);
    check("t1_alive", 32'(alive0), 32'he);
    cyc();
    check("t1_pulse", 32'(hit0), 32'h0);

    // 2: one pixel outside the radius
    do_start();
    fire(126, 100);
    check("t2_hit",   32'(hit0),   32'h0);
    check("t2_score", 32'(score0), 32'h0);
    fire(100, 74);
    check("t2_alive", 32'(alive0), 32'hf);

    // 3: screen edges
    place(0, 10, 10); place(3, 1015, 1015);
    do_start();
    fire(0, 0);
    check("t3_lo", 32'(hit0), 32'h1);
    fire(1023, 1023);
    check("t3_hi", 32'(hit0), 32'h8);
    check("t3_score", 32'(score0), 32'h2);

    // 4: two overlapping candidates, projectile held
    place(1, 300, 200); place(2, 300, 200);
    do_start();
    proj_h = 10'd300; proj_v = 10'd200; proj_valid = 1'b1;
    cyc();
    check("t4_hit",   32'(hit0),   32'h2);
    check("t4_alive", 32'(alive0), 32'hd);
    cyc();
    check("t4_hold",  32'(hit0),   32'h4);
    proj_valid = 1'b0;
    cyc();

    // 5: respawn timing and start priority
    do_start();
    fire(10, 10);
    dead = 0;
    for (int n = 0; n < 10; n++) begin
      if (!alive5[0]) dead++;
      cyc();
    end
    check("t5_dead_cycles", 32'(dead), 32'd5);
    check("t5_norespawn", 32'(alive0[0]), 32'h0);
    proj_h = 10'd10; proj_v = 10'd10; proj_valid = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("t5_st_alive", 32'(alive5), 32'hf);
    check("t5_st_hit",   32'(hit5),   32'h0);
    check("t5_st_cons",  32'(cons0),  32'h0);
    cyc();
    proj_valid = 1'b0;
    check("t5_after", 32'(hit0), 32'h1);

    // 6: clear the board then reset mid-round
    place(2, 500, 500);
    do_start();
    fire(10, 10); fire(300, 200); fire(500, 500); fire(1015, 1015);
    check("t6_clr0",  32'(clr0),   32'h1);
    check("t6_clr5",  32'(clr5),   32'h1);
    check("t6_score", 32'(score0), 32'h4);
    reset_n = 1'b0;
    #1;
    check("t6_rst0", {alive0, hit0, cons0, clr0, score0}, 32'h0);
    check("t6_rst5", {alive5, hit5, cons5, clr5, score5}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
